// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

   localparam int MD_WIDTH  = 32;
   localparam int MUL_ITERS = MD_WIDTH / 2;
   localparam int DIV_ITERS = MD_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      BD_ZERO = 3'd0,
      BD_P1   = 3'd1,
      BD_P2   = 3'd2,
      BD_M1   = 3'd3,
      BD_M2   = 3'd4
   } booth_digit_t;

   // Window is {b[2i+1], b[2i], b[2i-1]}.
   function automatic booth_digit_t booth_decode(input logic [2:0] w);
      booth_digit_t d;
      case (w)
         3'b001, 3'b010: d = BD_P1;
         3'b011:         d = BD_P2;
         3'b100:         d = BD_M2;
         3'b101, 3'b110: d = BD_M1;
         default:        d = BD_ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/multdiv_iter_if.sv
// Request/result bundle of multdiv_iter plus a debug view of its FSM state.
interface multdiv_iter_if #(parameter int WIDTH = 32);
   import multdiv_pkg::*;

   // ctrl_MULT/ctrl_DIV are one-cycle starts taken only in IDLE (no ready back);
   // data_resultRDY is a one-cycle valid for data_result/data_exception, no back-pressure.
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;
   state_t           state;

   modport master (
      output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
      input  data_result, data_exception, data_resultRDY, busy, state
   );

   modport slave (
      input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
      output data_result, data_exception, data_resultRDY, busy, state
   );

endinterface

// File: rtl/multdiv_iter_booth_r4_sel.sv
// Radix-4 Booth selector: maps a 3-bit multiplier window to a WIDTH+1-bit addend.
module booth_r4_sel
   import multdiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic [2:0]       window,
   input  logic [WIDTH-1:0] mcand,
   output logic [WIDTH:0]   addend,
   output logic             cin
);

   // Negative digits are one's complement here; the +1 arrives as cin.
   always_comb begin
      addend = '0;
      cin    = 1'b0;
      case (booth_decode(window))
         BD_P1: addend = {mcand[WIDTH-1], mcand};
         BD_P2: addend = {mcand, 1'b0};
         BD_M1: begin
            addend = ~{mcand[WIDTH-1], mcand};
            cin    = 1'b1;
         end
         BD_M2: begin
            addend = ~{mcand, 1'b0};
            cin    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-4 Booth) / divide (non-restoring) unit.
// Optional build macro: MULTDIV_EARLY_ZERO_EN (short-circuits zero operands to FIN).
module multdiv_iter
   import multdiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic           clock,
   input  logic           reset,
   multdiv_iter_if.slave  bus
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] MUL_N = CW'(WIDTH / 2);
   localparam logic [CW-1:0] DIV_N = CW'(WIDTH);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [2*WIDTH:0] prod;
   logic             booth_q;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic             neg_q;
   logic             div_zero;
   logic [WIDTH-1:0] res_q;
   logic             exc_q;
   logic             rdy_q;
   logic             busy_q;

   logic [WIDTH:0]   addend;
   logic             cin;
   logic [WIDTH+1:0] mul_sum;
   logic [2*WIDTH:0] mul_next;
   logic             mul_ovf;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] quo_final;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             start;
   logic             early;

   booth_r4_sel #(.WIDTH(WIDTH)) u_sel (
      .window ({prod[1:0], booth_q}),
      .mcand  (mcand),
      .addend (addend),
      .cin    (cin)
   );

   // Upper WIDTH+1 bits accumulate; the multiplier shifts out of the low half.
   always_comb begin
      mul_sum  = {prod[2*WIDTH], prod[2*WIDTH:WIDTH]} + {addend[WIDTH], addend}
               + {{(WIDTH+1){1'b0}}, cin};
      mul_next = {mul_sum[WIDTH+1], mul_sum, prod[WIDTH-1:2]};
      mul_ovf  = !((&mul_next[2*WIDTH:WIDTH-1]) || !(|mul_next[2*WIDTH:WIDTH-1]));
   end

   always_comb begin
      rem_sh    = {rem[WIDTH-1:0], quo[WIDTH-1]};
      rem_next  = rem[WIDTH] ? rem_sh + {1'b0, dvsr} : rem_sh - {1'b0, dvsr};
      quo_next  = {quo[WIDTH-2:0], ~rem_next[WIDTH]};
      quo_final = neg_q ? -quo_next : quo_next;
      a_mag     = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
      b_mag     = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
      start     = bus.ctrl_MULT || bus.ctrl_DIV;
`ifdef MULTDIV_EARLY_ZERO_EN
      early = bus.ctrl_MULT ? (bus.data_operandA == '0 || bus.data_operandB == '0)
                            : (bus.data_operandA == '0 && bus.data_operandB != '0);
`else
      early = 1'b0;
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         prod     <= '0;
         booth_q  <= 1'b0;
         mcand    <= '0;
         rem      <= '0;
         quo      <= '0;
         dvsr     <= '0;
         neg_q    <= 1'b0;
         div_zero <= 1'b0;
         res_q    <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         rdy_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  busy_q <= 1'b1;
                  if (early) begin
                     state <= ST_FIN;
                     rdy_q <= 1'b1;
                     res_q <= '0;
                     exc_q <= 1'b0;
                  end else if (bus.ctrl_MULT) begin
                     state   <= ST_MUL;
                     prod    <= {{(WIDTH+1){1'b0}}, bus.data_operandB};
                     booth_q <= 1'b0;
                     mcand   <= bus.data_operandA;
                     cnt     <= MUL_N;
                  end else begin
                     state    <= ST_DIV;
                     rem      <= '0;
                     quo      <= a_mag;
                     dvsr     <= b_mag;
                     neg_q    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                     div_zero <= (bus.data_operandB == '0);
                     cnt      <= DIV_N;
                  end
               end
            end
            ST_MUL: begin
               prod    <= mul_next;
               booth_q <= prod[1];
               cnt     <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= ST_FIN;
                  rdy_q <= 1'b1;
                  res_q <= mul_next[WIDTH-1:0];
                  exc_q <= mul_ovf;
               end
            end
            ST_DIV: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= ST_FIN;
                  rdy_q <= 1'b1;
                  res_q <= div_zero ? '0 : quo_final;
                  exc_q <= div_zero;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_result    = res_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = rdy_q;
   assign bus.busy           = busy_q;
   assign bus.state          = state;

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter: latency, results, exceptions, ignored starts, mid-op reset.
module tb_multdiv_iter;
   import multdiv_pkg::*;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   logic [63:0] exp_q[$];

`ifdef MULTDIV_EARLY_ZERO_EN
   localparam int ZLAT_MUL = 1;
   localparam int ZLAT_DIV = 1;
`else
   localparam int ZLAT_MUL = MUL_ITERS + 1;
   localparam int ZLAT_DIV = DIV_ITERS + 1;
`endif

   multdiv_iter_if #(.WIDTH(32)) bus ();

   multdiv_iter #(.WIDTH(32)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after a clock edge with the unit in IDLE; returns in the IDLE cycle after RDY.
   task automatic do_op(input string tag, input logic is_mul, input logic is_div,
                        input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_exc);
      int n;
      logic seen;
      logic [63:0] exp_v;
      bus.ctrl_MULT     = is_mul;
      bus.ctrl_DIV      = is_div;
      bus.data_operandA = a;
      bus.data_operandB = b;
      exp_q.push_back({31'd0, exp_exc, exp_res});
      n    = 0;
      seen = 1'b0;
      while (n < 60 && !seen) begin
         tick();
         n++;
         if (n == 1) begin
            bus.ctrl_MULT = 1'b0;
            bus.ctrl_DIV  = 1'b0;
         end
         if (bus.data_resultRDY) seen = 1'b1;
      end
      check({tag, " latency"}, 64'(n), 64'(exp_lat));
      exp_v = exp_q.pop_front();
      check({tag, " result"}, {31'd0, bus.data_exception, bus.data_result}, exp_v);
      tick();
      check({tag, " busy_after"}, {63'd0, bus.busy}, 64'd0);
   endtask

   initial begin
      int rdy_cnt;
      logic [31:0] held;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      repeat (3) tick();
      check("rst result", {32'd0, bus.data_result}, 64'd0);
      check("rst exc", {63'd0, bus.data_exception}, 64'd0);
      check("rst rdy", {63'd0, bus.data_resultRDY}, 64'd0);
      check("rst busy", {63'd0, bus.busy}, 64'd0);
      check("rst state", {62'd0, bus.state}, {62'd0, ST_IDLE});
      rst_n = 1'b1;
      tick();

      do_op("mul 7*-3",      1, 0, 32'd7,          32'hFFFF_FFFD, 17, 32'hFFFF_FFEB, 1'b0);
      do_op("mul ovf 2^32",  1, 0, 32'h0001_0000,  32'h0001_0000, 17, 32'h0000_0000, 1'b1);
      do_op("mul -5*-6",     1, 0, 32'hFFFF_FFFB,  32'hFFFF_FFFA, 17, 32'd30,        1'b0);
      do_op("mul max*2",     1, 0, 32'h7FFF_FFFF,  32'd2,         17, 32'hFFFF_FFFE, 1'b1);
      do_op("mul min*-1",    1, 0, 32'h8000_0000,  32'hFFFF_FFFF, 17, 32'h8000_0000, 1'b1);
      do_op("mul min*min",   1, 0, 32'h8000_0000,  32'h8000_0000, 17, 32'h0000_0000, 1'b1);
      do_op("mul min*1",     1, 0, 32'h8000_0000,  32'd1,         17, 32'h8000_0000, 1'b0);
      do_op("mul 0*123",     1, 0, 32'd0,          32'd123,       ZLAT_MUL, 32'd0,   1'b0);

      do_op("div -7/2",      0, 1, 32'hFFFF_FFF9,  32'd2,         33, 32'hFFFF_FFFD, 1'b0);
      held = bus.data_result;
      repeat (3) tick();
      check("held result", {32'd0, bus.data_result}, {32'd0, held});
      do_op("div 5/0",       0, 1, 32'd5,          32'd0,         33, 32'd0,         1'b1);
      do_op("div min/-1",    0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b0);
      do_op("div 100/-7",    0, 1, 32'd100,        32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 1'b0);
      do_op("div -100/-7",   0, 1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 33, 32'd14,        1'b0);
      do_op("div 7/9",       0, 1, 32'd7,          32'd9,         33, 32'd0,         1'b0);
      do_op("div min/1",     0, 1, 32'h8000_0000,  32'd1,         33, 32'h8000_0000, 1'b0);
      do_op("div max/3",     0, 1, 32'h7FFF_FFFF,  32'd3,         33, 32'h2AAA_AAAA, 1'b0);
      do_op("div 0/5",       0, 1, 32'd0,          32'd5,         ZLAT_DIV, 32'd0,   1'b0);
      do_op("div 0/0",       0, 1, 32'd0,          32'd0,         33, 32'd0,         1'b1);

      // Both starts together, a start mid-op and a start in the FIN cycle.
      bus.ctrl_MULT     = 1'b1;
      bus.ctrl_DIV      = 1'b1;
      bus.data_operandA = 32'd6;
      bus.data_operandB = 32'd3;
      rdy_cnt = 0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (n == 1) begin
            bus.ctrl_MULT = 1'b0;
            bus.ctrl_DIV  = 1'b0;
         end
         if (n == 5) begin
            bus.ctrl_DIV      = 1'b1;
            bus.data_operandA = 32'd100;
            bus.data_operandB = 32'd1;
         end
         if (n == 6) bus.ctrl_DIV = 1'b0;
         if (n == 17) bus.ctrl_MULT = 1'b1;
         if (n == 18) bus.ctrl_MULT = 1'b0;
         if (bus.data_resultRDY) rdy_cnt++;
      end
      check("both rdy count", 64'(rdy_cnt), 64'd1);
      check("both result", {31'd0, bus.data_exception, bus.data_result}, 64'd18);
      check("both idle", {62'd0, bus.state}, {62'd0, ST_IDLE});

      // Reset asserted in the middle of a divide.
      bus.ctrl_DIV      = 1'b1;
      bus.data_operandA = 32'd1000;
      bus.data_operandB = 32'd3;
      rdy_cnt = 0;
      for (int n = 1; n <= 10; n++) begin
         tick();
         if (n == 1) bus.ctrl_DIV = 1'b0;
         if (bus.data_resultRDY) rdy_cnt++;
      end
      rst_n = 1'b0;
      #1;
      check("midrst result", {32'd0, bus.data_result}, 64'd0);
      check("midrst busy", {63'd0, bus.busy}, 64'd0);
      check("midrst state", {62'd0, bus.state}, {62'd0, ST_IDLE});
      repeat (2) tick();
      rst_n = 1'b1;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (bus.data_resultRDY) rdy_cnt++;
      end
      check("midrst no rdy", 64'(rdy_cnt), 64'd0);
      do_op("mul 2*3",       1, 0, 32'd2,          32'd3,         17, 32'd6,         1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
